mul_share_ctrl: RTL and testbench
=================================

Name: mul_share_ctrl

Overview:
- Sequencer/arbiter that shares one multiplier_8b_wrapper between two requesters.
- Accepts 8x8 operand pairs on a valid/ready handshake and arbitrates round-robin.
- Drives the wrapper's 3-bit command / 8-bit byte-serial interface through load, start, wait and two read phases.
- Returns the 16-bit product with the requester ID on a backpressurable response channel; sits between the tt_um top's I/O decode and the multiplier datapath.

Parameters:
- MUL_LAT, 4, cycles from the START command until the product is readable (1..15)
- NREQ, 2, number of requesters; fixed at 2 in this revision

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  per-requester operand valid
- req_ready  out  2  per-requester accept; one-hot or zero
- req_a  in  16  operand A, requester i on bits [8i+7:8i]
- req_b  in  16  operand B, same packing
- rsp_valid  out  1  product valid
- rsp_ready  in  1  consumer accepts product
- rsp_id  out  1  requester that owns rsp_product
- rsp_product  out  16  {hi byte, lo byte} read from the wrapper
- mul_comm  out  3  command to the wrapper's comm input
- mul_in  out  8  data to the wrapper's in_8b input
- mul_out  in  8  wrapper's out_8b
- busy  out  1  high whenever state != IDLE

Behaviour:
- Command encoding (shared package): NOP=0, LOAD_A=1, LOAD_B=2, START=3, READ_LO=4, READ_HI=5; codes 6 and 7 are never issued.
- Wrapper read latency is fixed at 1: mul_out is valid the cycle after READ_x is presented.
- Reset (async assert, sync release) forces:
  - state=IDLE, last_grant=1, so requester 0 wins first.
  - rsp_valid=0, rsp_id=0, rsp_product=0, mul_comm=NOP, mul_in=0, busy=0.
  - Operand registers = 0.
- Reset mid-operation drops the transaction silently; the wrapper shares rst_n.
- States: IDLE -> LDA -> LDB -> STRT -> WAIT -> RDLO -> RDHI -> CAPHI -> RESP -> IDLE.
- IDLE:
  - req_ready[i] = req_valid[i] & grant[i], combinational.
  - grant: the only valid requester, or, when both are valid, the requester != last_grant.
  - On handshake: latch a/b/id, update last_grant, go to LDA.
  - mul_comm = NOP.
- LDA: mul_comm=LOAD_A, mul_in=a. LDB: mul_comm=LOAD_B, mul_in=b. STRT: mul_comm=START, cycle counter loaded with MUL_LAT-1.
- WAIT: mul_comm=NOP; stay exactly MUL_LAT cycles, decrementing the counter; exit when the counter is 0.
- RDLO: mul_comm=READ_LO.
- RDHI: mul_comm=READ_HI; capture mul_out into product[7:0].
- CAPHI: mul_comm=NOP; capture mul_out into product[15:8].
- RESP:
  - rsp_valid=1; rsp_id and rsp_product stable until rsp_ready.
  - On rsp_valid & rsp_ready go to IDLE; rsp_valid drops next cycle.
  - No new request is accepted during RESP; the earliest next accept is the first IDLE cycle.
- mul_in = 0 in every state except LDA and LDB.
- mul_comm and mul_in are decoded from registered state and operands only (Moore), with no combinational path from req_* or rsp_ready.
- Latency: accept at cycle 0 -> rsp_valid first high at cycle 7+MUL_LAT (11 for the default).
- Throughput: one product per 8+MUL_LAT cycles with rsp_ready held high.
- A requester dropping req_valid without a handshake has no effect.
- req_a/req_b changes after a handshake are ignored because operands are latched.

Decomposition:
- Package mul_ctrl_pkg holds:
  - the command localparams (NOP..READ_HI) and COMM_W=3;
  - the state enum encoding (4-bit);
  - the read latency constant RD_LAT=1.
- One sub-module, rr_arb2: a 2-way round-robin arbiter with valid[1:0], last_grant in, and one-hot grant[1:0] out.

Test Plan (bench wrapper stub returns the exact product with 1-cycle read latency):
- Single op: reset, req_valid=01, a0=0x12, b0=0x34, rsp_ready=1 -> mul_comm sequence 1,2,3,0,0,0,0,4,5,0; rsp_valid at cycle 11; rsp_product=0x03A8, rsp_id=0.
- Contention: both valid from reset, a0/b0=0xFF/0xFF, a1/b1=0x02/0x03 -> first response id=0, 0xFE01; second id=1, 0x0006; then with both still valid, the next grant goes to 0.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_product and rsp_id stable, no req_ready asserted; release -> IDLE next cycle.
- Reset mid-op: assert rst_n=0 during WAIT -> all outputs at reset values immediately (async); after release, a new request to requester 1 completes normally.
- Parameter sweep: MUL_LAT=1 and 15 -> rsp_valid at cycles 8 and 22 after accept; WAIT lasts exactly MUL_LAT cycles.
- Operand hold: change req_a right after the handshake -> LOAD_A carries the latched value; 0x00*0xAB=0x0000.

Source files
------------

// File: rtl/mul_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  mul_ctrl_pkg
//  Shared wrapper command codes, controller state encoding, read latency.
//  Revision: 1.0
// ============================================================================
package mul_ctrl_pkg;

    localparam int COMM_W = 3;

    localparam logic [COMM_W-1:0] NOP     = 3'd0;
    localparam logic [COMM_W-1:0] LOAD_A  = 3'd1;
    localparam logic [COMM_W-1:0] LOAD_B  = 3'd2;
    localparam logic [COMM_W-1:0] START   = 3'd3;
    localparam logic [COMM_W-1:0] READ_LO = 3'd4;
    localparam logic [COMM_W-1:0] READ_HI = 3'd5;

    // mul_out is valid the cycle after a READ_x command is presented
    localparam int RD_LAT = 1;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_LDA   = 4'd1,
        ST_LDB   = 4'd2,
        ST_STRT  = 4'd3,
        ST_WAIT  = 4'd4,
        ST_RDLO  = 4'd5,
        ST_RDHI  = 4'd6,
        ST_CAPHI = 4'd7,
        ST_RESP  = 4'd8
    } state_e;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  rr_arb2
//  Two-way round-robin arbiter; on contention the requester that did not win
//  last time is granted. Grant is one-hot or zero.
//  Revision: 1.0
// ============================================================================
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    assign grant_o[0] = valid_i[0] & (~valid_i[1] |  last_grant_i);
    assign grant_o[1] = valid_i[1] & (~valid_i[0] | ~last_grant_i);

endmodule
`default_nettype wire

// File: rtl/mul_share_ctrl.sv
`default_nettype none
// ============================================================================
//  mul_share_ctrl
//  Shares one byte-serial 8x8 multiplier wrapper between two requesters and
//  returns {hi,lo} products with the owner ID on a backpressurable channel.
//  Revision: 1.0
// ============================================================================
module mul_share_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int NREQ    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [8*NREQ-1:0]   req_a,
    input  logic [8*NREQ-1:0]   req_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [15:0]         rsp_product,
    output logic [COMM_W-1:0]   mul_comm,
    output logic [7:0]          mul_in,
    input  logic [7:0]          mul_out,
    output logic                busy
);

    if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_bad_mul_lat
        $error("mul_share_ctrl: MUL_LAT must be within 1..15");
    end
    if (NREQ != 2) begin : g_bad_nreq
        $error("mul_share_ctrl: only NREQ == 2 is supported");
    end
    if (RD_LAT != 1) begin : g_bad_rd_lat
        $error("mul_share_ctrl: capture sequencing assumes a read latency of 1");
    end

    localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

    state_e      state_q, state_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic        id_q, id_d;
    logic        last_q, last_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] prod_q, prod_d;

    logic [1:0]  grant;
    logic        sel;

    rr_arb2 u_arb (
        .valid_i      (req_valid),
        .last_grant_i (last_q),
        .grant_o      (grant)
    );

    assign sel = grant[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= 4'd0;
            prod_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            id_q    <= id_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        id_d      = id_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        req_ready = '0;

        case (state_q)
            ST_IDLE: begin
                req_ready = grant;
                if (|grant) begin
                    a_d     = req_a[{sel, 3'b000} +: 8];
                    b_d     = req_b[{sel, 3'b000} +: 8];
                    id_d    = sel;
                    last_d  = sel;
                    state_d = ST_LDA;
                end
            end
            ST_LDA:  state_d = ST_LDB;
            ST_LDB:  state_d = ST_STRT;
            ST_STRT: begin
                cnt_d   = CNT_INIT;
                state_d = ST_WAIT;
            end
            // counter runs MUL_LAT-1 .. 0, so WAIT lasts exactly MUL_LAT cycles
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RDLO;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RDLO: state_d = ST_RDHI;
            ST_RDHI: begin
                prod_d[7:0] = mul_out;
                state_d     = ST_CAPHI;
            end
            ST_CAPHI: begin
                prod_d[15:8] = mul_out;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Wrapper drive depends only on registered state and operands
    always_comb begin
        mul_comm = NOP;
        mul_in   = 8'h00;
        case (state_q)
            ST_LDA: begin
                mul_comm = LOAD_A;
                mul_in   = a_q;
            end
            ST_LDB: begin
                mul_comm = LOAD_B;
                mul_in   = b_q;
            end
            ST_STRT: mul_comm = START;
            ST_RDLO: mul_comm = READ_LO;
            ST_RDHI: mul_comm = READ_HI;
            default: mul_comm = NOP;
        endcase
    end

    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_id      = id_q;
    assign rsp_product = prod_q;
    assign busy        = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mul_share_ctrl.sv
`default_nettype none
// ============================================================================
//  tb_mul_share_ctrl
//  Self-checking bench: vector table, corner sequences, randomized traffic
//  against a transaction-level reference model, and a MUL_LAT sweep.
//  Revision: 1.0
// ============================================================================
module tb_mul_share_ctrl;

    localparam int ML = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [15:0] req_a = 16'h0000;
    logic [15:0] req_b = 16'h0000;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_id;
    logic [15:0] rsp_product;
    logic [2:0]  mul_comm;
    logic [7:0]  mul_in;
    logic [7:0]  mul_out;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mul_share_ctrl #(.MUL_LAT(ML), .NREQ(2)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
        .mul_comm    (mul_comm),
        .mul_in      (mul_in),
        .mul_out     (mul_out),
        .busy        (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Wrapper stub: product readable MUL_LAT cycles after START, else 0xEE
    logic [7:0]  m_a, m_b;
    logic [15:0] m_p;
    int          m_t;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_a <= 0; m_b <= 0; m_p <= 0; mul_out <= 0; m_t <= 0;
        end else begin
            if (m_t > 0) m_t <= m_t - 1;
            case (mul_comm)
                3'd1: m_a <= mul_in;
                3'd2: m_b <= mul_in;
                3'd3: begin m_p <= {8'h00, m_a} * {8'h00, m_b}; m_t <= ML - 1; end
                3'd4: mul_out <= (m_t == 0) ? m_p[7:0]  : 8'hEE;
                3'd5: mul_out <= (m_t == 0) ? m_p[15:8] : 8'hEE;
                default: ;
            endcase
        end
    end

    // ---------------- transaction-level reference model ----------------
    typedef struct { int id; logic [15:0] prod; int acc; } exp_t;
    exp_t        q[$];
    int          acc_log[$];
    int          acc_cyc[$];
    logic [15:0] rsp_log[$];
    bit          m_free = 1'b1;
    bit          m_last = 1'b1;
    bit          m_seen = 1'b0;
    bit          mon_en = 1'b0;
    bit          free_next;
    logic [1:0]  g_exp;
    exp_t        e_new;

    function automatic logic [1:0] ref_grant(input logic [1:0] v, input bit last);
        if (v == 2'b11) return last ? 2'b01 : 2'b10;
        return v;
    endfunction

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            free_next = 1'b0;
            if (q.size() > 0) begin
                if (rsp_valid && !m_seen) begin
                    chk("rsp_latency", cyc - q[0].acc, 7 + ML);
                    m_seen = 1'b1;
                end else if (!rsp_valid && !m_seen && (cyc - q[0].acc == 7 + ML)) begin
                    chk("rsp_valid_due", rsp_valid, 1);
                end
                if (rsp_valid) begin
                    chk("rsp_id", rsp_id, q[0].id);
                    chk("rsp_product", rsp_product, q[0].prod);
                    if (rsp_ready) begin
                        rsp_log.push_back(rsp_product);
                        void'(q.pop_front());
                        m_seen    = 1'b0;
                        free_next = 1'b1;
                    end
                end
            end else begin
                chk("rsp_valid_idle", rsp_valid, 0);
            end
            g_exp = m_free ? ref_grant(req_valid, m_last) : 2'b00;
            chk("req_ready", req_ready, g_exp);
            chk("busy", busy, !m_free);
            if (g_exp != 2'b00) begin
                e_new.id   = g_exp[1];
                e_new.prod = {8'h00, req_a[8*e_new.id +: 8]} * {8'h00, req_b[8*e_new.id +: 8]};
                e_new.acc  = cyc;
                q.push_back(e_new);
                acc_log.push_back(e_new.id);
                acc_cyc.push_back(cyc);
                m_last = g_exp[1];
                m_free = 1'b0;
            end
            if (free_next) m_free = 1'b1;
        end
    end

    task automatic model_clear();
        q.delete(); acc_log.delete(); acc_cyc.delete(); rsp_log.delete();
        m_free = 1'b1; m_last = 1'b1; m_seen = 1'b0;
    endtask

    task automatic do_reset();
        req_valid = 2'b00; rsp_ready = 1'b0; rst_n = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // ---------------- directed single operation ----------------
    logic [2:0] seq [10] = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0, 3'd4, 3'd5, 3'd0};

    task automatic run_op(input int id, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp_p, input logic [7:0] a_after);
        int n;
        req_a[8*id +: 8] = a;
        req_b[8*id +: 8] = b;
        req_valid = 2'b01 << id;
        rsp_ready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (req_ready == 2'b00 && n < 60);
        chk("op_accept", req_ready, 2'b01 << id);
        @(posedge clk);
        #1 req_valid = 2'b00;
        req_a[8*id +: 8] = a_after;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("op_comm[%0d]", k), mul_comm, seq[k]);
            chk($sformatf("op_in[%0d]", k), mul_in, (k == 0) ? a : ((k == 1) ? b : 8'h00));
        end
        @(negedge clk);
        chk("op_rsp_valid", rsp_valid, 1);
        chk("op_product", rsp_product, exp_p);
        chk("op_id", rsp_id, id);
        @(posedge clk);
        #1;
    endtask

    typedef struct { int id; logic [7:0] a; logic [7:0] b; logic [15:0] p; } vec_t;
    vec_t tbl [6];

    // ---------------- MUL_LAT sweep instances ----------------
    bit sweep_go = 1'b0;

    for (genvar g = 0; g < 2; g++) begin : g_sweep
        localparam int L = (g == 0) ? 1 : 15;
        logic [1:0]  v = 2'b00;
        logic [1:0]  rdy;
        logic [15:0] a16 = 16'h0000;
        logic [15:0] b16 = 16'h0000;
        logic        rv, rid, bsy;
        logic [15:0] prod;
        logic [2:0]  comm;
        logic [7:0]  min, mout;
        logic [7:0]  sa, sb;
        logic [15:0] sp;
        int          st;
        bit          done = 1'b0;

        mul_share_ctrl #(.MUL_LAT(L), .NREQ(2)) u_dut (
            .clk (clk), .rst_n (rst_n),
            .req_valid (v), .req_ready (rdy), .req_a (a16), .req_b (b16),
            .rsp_valid (rv), .rsp_ready (1'b1), .rsp_id (rid), .rsp_product (prod),
            .mul_comm (comm), .mul_in (min), .mul_out (mout), .busy (bsy)
        );

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sa <= 0; sb <= 0; sp <= 0; mout <= 0; st <= 0;
            end else begin
                if (st > 0) st <= st - 1;
                case (comm)
                    3'd1: sa <= min;
                    3'd2: sb <= min;
                    3'd3: begin sp <= {8'h00, sa} * {8'h00, sb}; st <= L - 1; end
                    3'd4: mout <= (st == 0) ? sp[7:0]  : 8'hEE;
                    3'd5: mout <= (st == 0) ? sp[15:8] : 8'hEE;
                    default: ;
                endcase
            end
        end

        initial begin
            int n, k, s_at, r_at;
            bit got;
            wait (sweep_go);
            @(posedge clk);
            #1 a16 = 16'h00C3; b16 = 16'h005A; v = 2'b01;
            n = 0;
            do begin @(negedge clk); n++; end while (rdy == 2'b00 && n < 50);
            chk($sformatf("sweep%0d_accept", L), rdy, 2'b01);
            @(posedge clk);
            #1 v = 2'b00;
            s_at = -1; r_at = -1; k = 0; got = 1'b0;
            while (!got && k < 40) begin
                @(negedge clk);
                k++;
                if (comm == 3'd3) s_at = k;
                if (comm == 3'd4 && r_at < 0) r_at = k;
                if (rv) got = 1'b1;
            end
            chk($sformatf("sweep%0d_rsp_latency", L), k, 7 + L);
            chk($sformatf("sweep%0d_wait_cycles", L), r_at - s_at - 1, L);
            chk($sformatf("sweep%0d_product", L), prod, 16'h448E);
            done = 1'b1;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int n;
        logic [15:0] p0;
        tbl[0] = '{0, 8'h12, 8'h34, 16'h03A8};
        tbl[1] = '{1, 8'hFF, 8'hFF, 16'hFE01};
        tbl[2] = '{0, 8'h02, 8'h03, 16'h0006};
        tbl[3] = '{1, 8'h80, 8'h02, 16'h0100};
        tbl[4] = '{0, 8'h0F, 8'h11, 16'h00FF};
        tbl[5] = '{1, 8'hAB, 8'hCD, 16'h88EF};

        // reset values, both during and just after reset
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_comm", mul_comm, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_product", rsp_product, 0);
        chk("rst_mul_in", mul_in, 0);
        chk("rst_req_ready", req_ready, 0);
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++)
            run_op(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].p, ~tbl[i].a);

        // operand hold: req_a changes right after the handshake
        run_op(0, 8'h00, 8'hAB, 16'h0000, 8'h5A);

        // backpressure with the other requester waiting
        req_a[7:0] = 8'h21; req_b[7:0] = 8'h13; req_valid = 2'b01; rsp_ready = 1'b0;
        n = 0;
        do begin @(posedge clk); n++; end while (acc_log.size() == 0 && n < 60);
        #1 req_valid = 2'b10; req_a[15:8] = 8'h07; req_b[15:8] = 8'h09;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 40);
        chk("bp_rsp_valid", rsp_valid, 1);
        p0 = rsp_product;
        chk("bp_product", p0, 16'h0273);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_hold_valid", rsp_valid, 1);
            chk("bp_hold_product", rsp_product, 16'h0273);
            chk("bp_hold_id", rsp_id, 0);
            chk("bp_hold_ready", req_ready, 0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1; req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_valid", rsp_valid, 0);
        chk("bp_release_busy", busy, 0);
        @(posedge clk);
        #1;

        // asynchronous reset in the middle of WAIT
        req_a[15:8] = 8'h44; req_b[15:8] = 8'h55; req_valid = 2'b10; rsp_ready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (req_ready == 2'b00 && n < 60);
        @(posedge clk);
        #1 req_valid = 2'b00;
        repeat (4) @(negedge clk);
        chk("mid_busy", busy, 1);
        #2 rst_n = 1'b0;
        model_clear();
        #1;
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_rsp_id", rsp_id, 0);
        chk("mid_rst_product", rsp_product, 0);
        chk("mid_rst_comm", mul_comm, 0);
        chk("mid_rst_mul_in", mul_in, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", req_ready, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_op(1, 8'h0B, 8'h0D, 16'h008F, 8'h00);

        // contention from reset: grants 0, 1, then 0 again
        do_reset();
        req_a = {8'h02, 8'hFF}; req_b = {8'h03, 8'hFF}; req_valid = 2'b11; rsp_ready = 1'b1;
        n = 0;
        while (acc_log.size() < 3 && n < 100) begin @(posedge clk); n++; end
        #1 req_valid = 2'b00;
        n = 0;
        while (q.size() > 0 && n < 40) begin @(posedge clk); n++; end
        chk("cont_accepts", acc_log.size(), 3);
        chk("cont_responses", rsp_log.size(), 3);
        if (acc_log.size() >= 3 && rsp_log.size() >= 2) begin
            chk("cont_grant0", acc_log[0], 0);
            chk("cont_grant1", acc_log[1], 1);
            chk("cont_grant2", acc_log[2], 0);
            chk("cont_prod0", rsp_log[0], 16'hFE01);
            chk("cont_prod1", rsp_log[1], 16'h0006);
            chk("cont_throughput", acc_cyc[1] - acc_cyc[0], 8 + ML);
        end

        // MUL_LAT = 1 and 15
        @(posedge clk);
        #1 sweep_go = 1'b1;
        n = 0;
        while (!(g_sweep[0].done && g_sweep[1].done) && n < 200) begin @(posedge clk); n++; end
        chk("sweep_done", {g_sweep[1].done, g_sweep[0].done}, 2'b11);

        // randomized traffic checked by the reference model
        acc_log.delete();
        for (int c = 0; c < 800; c++) begin
            @(posedge clk);
            #1;
            req_valid = 2'($urandom_range(0, 3));
            req_a     = 16'($urandom);
            req_b     = 16'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        req_valid = 2'b00; rsp_ready = 1'b1;
        n = 0;
        while (q.size() > 0 && n < 60) begin @(posedge clk); n++; end
        chk("rand_drained", q.size(), 0);
        chk("rand_progress", acc_log.size() > 20, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
